// File: rtl/hilo_muldiv_unit_pkg.sv
// rtl/hilo_muldiv_unit_pkg.sv - shared constants, states and helpers for the HI/LO mul/div unit
package hilo_muldiv_unit_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // 0x80000000 maps onto itself, which is exactly the unsigned magnitude we want.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - command/result bundle between issue logic and the mul/div unit
interface hilo_muldiv_unit_if;
    import hilo_muldiv_unit_pkg::*;

    logic            op_valid;
    logic [2:0]      op_code;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            cancel;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;

    modport master (
        output op_valid, op_code, src_a, src_b, cancel,
        input  busy, done, hi_out, lo_out
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, cancel,
        output busy, done, hi_out, lo_out
    );

endinterface

// File: rtl/hilo_muldiv_unit_muldiv_iter_dp.sv
// rtl/hilo_muldiv_unit_muldiv_iter_dp.sv - one radix-2 shift-add / restoring-divide step plus sign fix
module muldiv_iter_dp
    import hilo_muldiv_unit_pkg::*;
(
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    input  logic              i_neg_hi,
    input  logic              i_neg_lo,
    output logic [2*XLEN-1:0] o_acc_next,
    output logic [XLEN-1:0]   o_hi_fix,
    output logic [XLEN-1:0]   o_lo_fix
);

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
    logic [XLEN:0]     w_add;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_prod_neg;

    assign w_add      = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd};
    assign w_rem_sh   = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    assign w_trial    = w_rem_sh - {1'b0, i_opnd};
    assign w_prod_neg = ~i_acc + 1'b1;

    always_comb begin
        o_acc_next = i_acc;
        if (i_is_div) begin
            if (w_trial[XLEN])
                o_acc_next = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
            else
                o_acc_next = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
        end else if (i_acc[0]) begin
            o_acc_next = {w_add, i_acc[XLEN-1:1]};
        end else begin
            o_acc_next = {1'b0, i_acc[2*XLEN-1:1]};
        end
    end

    always_comb begin
        o_hi_fix = i_acc[2*XLEN-1:XLEN];
        o_lo_fix = i_acc[XLEN-1:0];
        if (i_is_div) begin
            if (i_neg_hi) o_hi_fix = ~i_acc[2*XLEN-1:XLEN] + 1'b1;
            if (i_neg_lo) o_lo_fix = ~i_acc[XLEN-1:0] + 1'b1;
        end else if (i_neg_hi) begin
            o_hi_fix = w_prod_neg[2*XLEN-1:XLEN];
            o_lo_fix = w_prod_neg[XLEN-1:0];
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative MULT/DIV responder owning the architectural HI/LO registers
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    hilo_muldiv_unit_if.slave  bus
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic              r_neg_hi;
    logic              r_neg_lo;
    logic              r_is_div;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_done;

    logic              w_is_signed;
    logic              w_sign_xor;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN-1:0]   w_hi_fix;
    logic [XLEN-1:0]   w_lo_fix;

    assign w_is_signed = (bus.op_code == OP_MULT) || (bus.op_code == OP_DIV);
    assign w_sign_xor  = w_is_signed && (bus.src_a[XLEN-1] ^ bus.src_b[XLEN-1]);
    assign w_abs_a     = abs_val(bus.src_a, w_is_signed);
    assign w_abs_b     = abs_val(bus.src_b, w_is_signed);

    muldiv_iter_dp u_dp (
        .i_is_div   (r_is_div),
        .i_acc      (r_acc),
        .i_opnd     (r_opnd),
        .i_neg_hi   (r_neg_hi),
        .i_neg_lo   (r_neg_lo),
        .o_acc_next (w_acc_next),
        .o_hi_fix   (w_hi_fix),
        .o_lo_fix   (w_lo_fix)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.cancel) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (bus.op_valid) begin
                        case (bus.op_code)
                            OP_MULT, OP_MULTU: begin
                                r_acc    <= {{XLEN{1'b0}}, w_abs_b};
                                r_opnd   <= w_abs_a;
                                r_neg_hi <= w_sign_xor;
                                r_neg_lo <= w_sign_xor;
                                r_is_div <= 1'b0;
                                r_cnt    <= '0;
                                r_state  <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero leaves quotient all-ones unsigned, so its sign fix is suppressed.
                                r_acc    <= {{XLEN{1'b0}}, w_abs_a};
                                r_opnd   <= w_abs_b;
                                r_neg_hi <= w_is_signed && bus.src_a[XLEN-1];
                                r_neg_lo <= w_sign_xor && (bus.src_b != '0);
                                r_is_div <= 1'b1;
                                r_cnt    <= '0;
                                r_state  <= S_DIV;
                            end
                            OP_MTHI: r_hi <= bus.src_a;
                            OP_MTLO: r_lo <= bus.src_a;
                            default: ;
                        endcase
                    end
                    S_MUL, S_DIV: begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(ITER - 1))
                            r_state <= S_FIX;
                    end
                    S_FIX: begin
                        r_hi    <= w_hi_fix;
                        r_lo    <= w_lo_fix;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = r_done;
    assign bus.hi_out = r_hi;
    assign bus.lo_out = r_lo;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Execution-side responder for the multiply/divide/HI-LO command group produced by instruction decode: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Runs iterative radix-2 multiply and divide and owns the architectural HI/LO registers.
- Drives `busy` so that pipeline hazard logic stalls issue, and MFHI/MFLO reads, until results are committed.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITER, 32, iterations per multiply/divide; equals XLEN.
- CNT_W, 6, iteration counter width; must satisfy ITER < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  command present this cycle.
- op_code  in  3  command: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; values 6 and 7 are ignored.
- src_a  in  XLEN  rs value (multiplicand / dividend / MT data).
- src_b  in  XLEN  rt value (multiplier / divisor).
- cancel  in  1  flush from the exception path; aborts the in-flight operation.
- busy  out  1  operation in flight (state != IDLE).
- done  out  1  one-cycle pulse: HI/LO hold the new result.
- hi_out  out  XLEN  HI register.
- lo_out  out  XLEN  LO register.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, counter=0, HI=0, LO=0, busy=0, done=0.
- States: IDLE, MUL, DIV, FIX. The state register is the only source of `busy`.
- IDLE + op_valid + MULT/MULTU:
  - Latch |a| and |b| (raw values for MULTU) and the result sign = a[31]^b[31] (signed only).
  - Clear the accumulator; counter=0; go to MUL.
- IDLE + op_valid + DIV/DIVU:
  - Latch |a| and |b| (raw for DIVU), quotient sign = a[31]^b[31], remainder sign = a[31].
  - Go to DIV.
- IDLE + op_valid + MTHI or MTLO:
  - HI (resp. LO) <= src_a at the next edge; state stays IDLE.
  - busy stays 0; done=0.
- MUL: one shift-add step per cycle over the 64-bit product; counter++; after ITER steps go to FIX.
- DIV: one restoring step per cycle (shift the remainder in, trial-subtract the divisor, set the quotient bit); after ITER steps go to FIX.
- FIX:
  - Apply two's-complement sign correction: product negated if its sign is set; quotient and remainder negated independently.
  - Write HI/LO. MUL: HI=product[63:32], LO=product[31:0]. DIV: HI=remainder, LO=quotient.
  - Go to IDLE; done=1 for the following cycle.
- Latency, with the accept edge as cycle 0:
  - busy=1 in cycles 1..ITER+1 (33 cycles).
  - The new HI/LO and done=1 are visible in cycle ITER+2 (34).
- While busy, op_valid is ignored for every op_code, MTHI/MTLO included. Upstream holds the command under stall. The bench flags op_valid&busy as a protocol error.
- cancel (has priority over all other inputs):
  - In MUL, DIV or FIX: go to IDLE at the next edge; HI/LO are unchanged and no done pulse is produced.
  - In IDLE: blocks acceptance of the same-cycle command.
- Divide by zero (no trap): HI=src_a, LO=32'hFFFFFFFF, for both DIV and DIVU; latency unchanged.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0 (wraps naturally).
- 0x80000000 operands: the magnitude is taken as unsigned 32-bit so it is representable; there is no special path.
- rst asserted mid-operation: everything returns to reset values immediately and HI/LO clear to 0.
- The unit has no interrupt, exception or overflow outputs.

Decomposition:
- Shared package holds:
  - op_code localparams (OP_MULT..OP_MTLO);
  - state encodings (S_IDLE, S_MUL, S_DIV, S_FIX);
  - XLEN.
- The decoder adds an op_code output driven from its existing mult/div/mthi/mtlo decode, using the package constants.
- One sub-module, muldiv_iter_dp: a combinational one-step datapath (shift-add step or restore step) plus the sign-fix negators.
- The FSM, counter and HI/LO registers stay in hilo_muldiv_unit.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> done in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy high for exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=7, b=0 -> HI=7, LO=0xFFFFFFFF.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> hi_out/lo_out update one cycle after each; busy never asserts; done stays 0.
- DIV started, cancel at cycle 10 -> busy=0 from cycle 11; HI/LO keep their prior values; no done pulse; a new MULT 5*6 is then accepted -> LO=30, HI=0.
- rst pulsed asynchronously mid-cycle during MUL -> busy, done, HI and LO read 0 before the next clock edge.
